// File: rtl/clock_ctrl_pkg.sv
// Shared types and constants for the digital clock time-setting controller.
// State encoding and blank-mask digit positions.
package clock_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      SET_H = 2'd1,
      SET_M = 2'd2
   } state_t;

   localparam int DIG_SU = 0;
   localparam int DIG_ST = 1;
   localparam int DIG_MU = 2;
   localparam int DIG_MT = 3;
   localparam int DIG_HU = 4;
   localparam int DIG_HT = 5;

   function automatic logic [5:0] blank_mask(input state_t s, input logic ph);
      logic [5:0] m;
      m = '0;
      case (s)
         SET_H: begin
            m[DIG_HT] = ph;
            m[DIG_HU] = ph;
         end
         SET_M: begin
            m[DIG_MT] = ph;
            m[DIG_MU] = ph;
         end
         default: m = '0;
      endcase
      // seconds digits never blink
      m[DIG_ST] = 1'b0;
      m[DIG_SU] = 1'b0;
      return m;
   endfunction

endpackage

// File: rtl/key_repeat.sv
// Key edge detector with hold-to-repeat; pulse is combinational from
// registered state so the parent can register it as its strobe.
module key_repeat #(
   parameter int REPEAT_DLY = 25_000_000,
   parameter int REPEAT_PER = 5_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic lvl,
   input  logic clr,
   output logic pulse
);

   localparam int MAXC = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
   localparam int CW = $clog2(MAXC + 1);
   localparam logic [CW-1:0] LIM_D = CW'(REPEAT_DLY - 1);
   localparam logic [CW-1:0] LIM_P = CW'(REPEAT_PER - 1);
   localparam logic [CW-1:0] SAT = CW'(MAXC);

   logic          s;
   logic          h;
   logic          armed;
   logic          first;
   logic [CW-1:0] cnt;
   logic          rise;
   logic          hit;

   always_comb begin
      rise  = s & ~h;
      hit   = armed & s & (cnt == (first ? LIM_D : LIM_P));
      pulse = en & ~clr & (rise | hit);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s     <= 1'b0;
         h     <= 1'b0;
         armed <= 1'b0;
         first <= 1'b0;
         cnt   <= '0;
      end else begin
         s <= lvl;
         h <= s;
         if (!en || clr || !s) begin
            armed <= 1'b0;
            first <= 1'b0;
            cnt   <= '0;
         end else if (pulse) begin
            armed <= 1'b1;
            first <= rise;
            cnt   <= '0;
         end else if (armed && cnt != SAT) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: run/set FSM, increment strobes, blink and timeout.
// Sits between the key debouncers and the counter/scan datapath.
module clock_set_ctrl
   import clock_ctrl_pkg::*;
#(
   parameter int REPEAT_DLY = 25_000_000,
   parameter int REPEAT_PER = 5_000_000,
   parameter int BLINK_HALF = 12_500_000,
   parameter int TIMEOUT_S  = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       mode_lvl,
   input  logic       inc_lvl,
   input  logic       tick_1hz,
   output logic       sec_en,
   output logic       inc_h,
   output logic       inc_m,
   output logic       clr_s,
   output logic [1:0] mode,
   output logic [5:0] blank
);

   localparam int TW = $clog2(TIMEOUT_S + 1);
   localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

   state_t        state;
   state_t        nxt;
   logic          m_s;
   logic          m_h;
   logic          mode_rise;
   logic          en;
   logic          tmo;
   logic          chg;
   logic          pulse;
   logic          phase;
   logic          ph_n;
   logic [BW-1:0] bcnt;
   logic [BW-1:0] bc_n;
   logic [TW-1:0] tcnt;

   always_comb begin
      mode_rise = m_s & ~m_h;
      en = (state == SET_H) || (state == SET_M);
      // a strobe in flight counts as key activity
      tmo = en & tick_1hz & ~mode_rise & ~(inc_h | inc_m)
          & (tcnt == TW'(TIMEOUT_S - 1));
      nxt = state;
      if (mode_rise) begin
         case (state)
            RUN:     nxt = SET_H;
            SET_H:   nxt = SET_M;
            default: nxt = RUN;
         endcase
      end else if (tmo || !en) begin
         nxt = RUN;
      end
      chg = (nxt != state);
   end

   always_comb begin
      ph_n = phase;
      bc_n = bcnt + 1'b1;
      if (chg || pulse) begin
         ph_n = 1'b0;
         bc_n = '0;
      end else if (bcnt == BW'(BLINK_HALF - 1)) begin
         ph_n = ~phase;
         bc_n = '0;
      end
   end

   key_repeat #(
      .REPEAT_DLY(REPEAT_DLY),
      .REPEAT_PER(REPEAT_PER)
   ) u_inc (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .lvl  (inc_lvl),
      .clr  (chg),
      .pulse(pulse)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
         m_s   <= 1'b0;
         m_h   <= 1'b0;
         inc_h <= 1'b0;
         inc_m <= 1'b0;
         clr_s <= 1'b0;
         blank <= '0;
         phase <= 1'b0;
         bcnt  <= '0;
         tcnt  <= '0;
      end else begin
         m_s   <= mode_lvl;
         m_h   <= m_s;
         state <= nxt;
         inc_h <= pulse & (state == SET_H);
         inc_m <= pulse & (state == SET_M);
         clr_s <= mode_rise & (state == SET_M);
         phase <= ph_n;
         bcnt  <= bc_n;
         blank <= blank_mask(nxt, ph_n);
         if (!en || chg || inc_h || inc_m)
            tcnt <= '0;
         else if (tick_1hz)
            tcnt <= tcnt + 1'b1;
      end
   end

   assign mode   = state;
   assign sec_en = tick_1hz & (state == RUN);

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl with small timing parameters.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_clock_set_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       mode_lvl;
   logic       inc_lvl;
   logic       tick_1hz;
   logic       sec_en;
   logic       inc_h;
   logic       inc_m;
   logic       clr_s;
   logic [1:0] mode;
   logic [5:0] blank;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   clock_set_ctrl #(
      .REPEAT_DLY(8),
      .REPEAT_PER(4),
      .BLINK_HALF(5),
      .TIMEOUT_S (3)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .mode_lvl(mode_lvl),
      .inc_lvl (inc_lvl),
      .tick_1hz(tick_1hz),
      .sec_en  (sec_en),
      .inc_h   (inc_h),
      .inc_m   (inc_m),
      .clr_s   (clr_s),
      .mode    (mode),
      .blank   (blank)
   );

   typedef struct {
      logic       m;
      logic       i;
      logic       t;
      logic [1:0] e_mode;
      logic       e_ih;
      logic       e_im;
      logic       e_clr;
      logic [5:0] e_blank;
      logic       e_sec;
   } vec_t;

   vec_t tv[11];

   function automatic vec_t mk(input logic m, input logic i, input logic t,
                               input logic [1:0] em, input logic eclr,
                               input logic esec);
      vec_t v;
      v.m = m;
      v.i = i;
      v.t = t;
      v.e_mode = em;
      v.e_ih = 1'b0;
      v.e_im = 1'b0;
      v.e_clr = eclr;
      v.e_blank = 6'd0;
      v.e_sec = esec;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic press_mode();
      @(negedge clk);
      mode_lvl = 1'b1;
      @(negedge clk);
      mode_lvl = 1'b0;
   endtask

   initial begin
      logic [31:0] obs_m;
      logic [31:0] obs_h;
      logic        any;

      rst = 1'b1;
      mode_lvl = 1'b0;
      inc_lvl = 1'b0;
      tick_1hz = 1'b0;

      // mode cycling: a press at row k shows at row k+2
      tv[0]  = mk(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
      tv[1]  = mk(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
      tv[2]  = mk(1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0);
      tv[3]  = mk(1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0);
      tv[4]  = mk(1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0);
      tv[5]  = mk(1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0);
      tv[6]  = mk(1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0);
      tv[7]  = mk(1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0);
      tv[8]  = mk(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
      tv[9]  = mk(1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1);
      tv[10] = mk(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);

      repeat (3) @(negedge clk);
      #1;
      chk("reset_state", {20'd0, mode, inc_h, inc_m, clr_s, blank, sec_en}, 32'd0);
      rst = 1'b0;

      for (int k = 0; k < 11; k++) begin
         @(negedge clk);
         mode_lvl = tv[k].m;
         inc_lvl = tv[k].i;
         tick_1hz = tv[k].t;
         #1;
         chk($sformatf("vec%0d", k),
             {20'd0, mode, inc_h, inc_m, clr_s, blank, sec_en},
             {20'd0, tv[k].e_mode, tv[k].e_ih, tv[k].e_im, tv[k].e_clr,
              tv[k].e_blank, tv[k].e_sec});
      end

      // auto-repeat in SET_M
      press_mode();
      press_mode();
      obs_m = '0;
      obs_h = '0;
      for (int j = 0; j < 28; j++) begin
         @(negedge clk);
         inc_lvl = (j < 20);
         #1;
         obs_m[j] = inc_m;
         obs_h[j] = inc_h;
      end
      chk("repeat_mode", {30'd0, mode}, 32'd2);
      chk("repeat_inc_m", obs_m, 32'h0004_4404);
      chk("repeat_inc_h", obs_h, 32'd0);

      // simultaneous mode and inc edges in SET_H
      press_mode();
      press_mode();
      any = 1'b0;
      for (int j = 0; j < 15; j++) begin
         @(negedge clk);
         mode_lvl = (j == 0);
         inc_lvl = 1'b1;
         #1;
         any = any | inc_h | inc_m;
      end
      chk("simul_mode", {30'd0, mode}, 32'd2);
      chk("simul_nostrobe", {31'd0, any}, 32'd0);
      @(negedge clk);
      inc_lvl = 1'b0;
      @(negedge clk);
      inc_lvl = 1'b1;
      @(negedge clk);
      #1;
      chk("repress_early", {30'd0, inc_h, inc_m}, 32'd0);
      @(negedge clk);
      #1;
      chk("repress_inc_m", {30'd0, inc_h, inc_m}, 32'd1);
      @(negedge clk);
      inc_lvl = 1'b0;

      // blink in SET_H
      press_mode();
      press_mode();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1;
         chk($sformatf("blink%0d", i), {26'd0, blank},
             (((i / 5) % 2) == 1) ? 32'h30 : 32'h0);
      end
      @(negedge clk);
      inc_lvl = 1'b1;
      for (int i = 1; i < 8; i++) begin
         @(negedge clk);
         if (i == 1) inc_lvl = 1'b0;
         #1;
         if (i == 2) chk("blink_inc_h", {31'd0, inc_h}, 32'd1);
         if (i >= 2 && i <= 6)
            chk($sformatf("blink_clr%0d", i), {26'd0, blank}, 32'h0);
         if (i == 7) chk("blink_resume", {26'd0, blank}, 32'h30);
      end

      // timeout from SET_M and sec_en gating
      press_mode();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         tick_1hz = (i % 3 == 0);
         #1;
         chk($sformatf("tmo_mode%0d", i), {30'd0, mode},
             (i >= 7) ? 32'd0 : 32'd2);
         chk($sformatf("tmo_sec%0d", i), {31'd0, sec_en},
             {31'd0, (i % 3 == 0) && (i >= 7)});
         chk($sformatf("tmo_clr%0d", i), {31'd0, clr_s}, 32'd0);
      end
      @(negedge clk);
      tick_1hz = 1'b0;

      // reset while repeating in SET_H
      press_mode();
      for (int j = 0; j < 13; j++) begin
         @(negedge clk);
         inc_lvl = 1'b1;
         #1;
         if (j == 10) chk("pre_rst_inc_h", {31'd0, inc_h}, 32'd1);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("rst_outputs", {21'd0, mode, inc_h, inc_m, clr_s, blank}, 32'd0);
      rst = 1'b0;
      any = 1'b0;
      for (int j = 0; j < 10; j++) begin
         @(negedge clk);
         #1;
         any = any | inc_h | inc_m;
      end
      chk("post_rst_run", {31'd0, any}, 32'd0);
      press_mode();
      for (int j = 0; j < 12; j++) begin
         @(negedge clk);
         #1;
         any = any | inc_h | inc_m;
      end
      chk("held_after_mode", {31'd0, any}, 32'd0);
      chk("held_mode", {30'd0, mode}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
